// File: rtl/sysid_pkg.sv
// sysid_pkg: shared state encoding, bus address constants and counter widths for the system-ID checker
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DRAIN, FINISH} state_t;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int TO_W = 16;
  localparam int RETRY_W = 4;
  localparam int DRAIN_W = 8;
endpackage

// File: rtl/sysid_rd_phase.sv
// sysid_rd_phase: one Avalon read phase (request + response wait) with a shared timeout counter
module sysid_rd_phase
  import sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        req,
  input  logic        pend,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        accept,
  output logic        valid,
  output logic        timeout,
  output logic [31:0] data
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n || clr) cnt <= '0;
    else if (req || pend) cnt <= cnt + 1'b1;
  always_comb begin
    accept  = req && !avm_waitrequest;
    valid   = pend && avm_readdatavalid;
    timeout = (req || pend) && !valid && (cnt == TO_W'(TIMEOUT_CYCLES - 1));
    data    = avm_readdata;
  end
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: boot-time read-and-compare of the system-ID slave with timeout, drain and retry
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRY      = 3,
  parameter int          DRAIN_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  state_t state, state_n;
  logic [RETRY_W-1:0] rcnt;
  logic [DRAIN_W-1:0] dcnt;
  logic rd, pend, clr, accept, valid, timeout, drain_end, retry_ok;
  logic [31:0] data;
  assign rd          = state == RD_ID || state == RD_TS;
  assign pend        = state == WAIT_ID || state == WAIT_TS;
  assign avm_read    = rd;
  assign avm_address = state == RD_TS ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign drain_end   = state == DRAIN && dcnt == DRAIN_W'(DRAIN_CYCLES - 1);
  assign retry_ok    = rcnt < RETRY_W'(MAX_RETRY);
  assign clr         = (state_n == RD_ID || state_n == RD_TS) && state_n != state;
  sysid_rd_phase #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_phase (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .req(rd),
    .pend(pend),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .accept(accept),
    .valid(valid),
    .timeout(timeout),
    .data(data)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RD_ID : IDLE;
      RD_ID:   state_n = timeout ? DRAIN : accept ? WAIT_ID : RD_ID;
      WAIT_ID: state_n = valid ? RD_TS : timeout ? DRAIN : WAIT_ID;
      RD_TS:   state_n = timeout ? DRAIN : accept ? WAIT_TS : RD_TS;
      WAIT_TS: state_n = valid ? CHECK : timeout ? DRAIN : WAIT_TS;
      CHECK:   state_n = FINISH;
      DRAIN:   state_n = !drain_end ? DRAIN : retry_ok ? RD_ID : FINISH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state       <= IDLE;
      rcnt        <= '0;
      dcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state <= state_n;
      busy  <= state_n != IDLE;
      done  <= state == FINISH;
      dcnt  <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        rcnt        <= '0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
        id_value    <= '0;
        ts_value    <= '0;
      end
      if (state == WAIT_ID && valid) id_value <= data;
      if (state == WAIT_TS && valid) ts_value <= data;
      if (state == CHECK) begin
        id_ok <= id_value == EXPECTED_ID;
        ts_ok <= ts_value == EXPECTED_TS;
      end
      if (drain_end && retry_ok) rcnt <= rcnt + 1'b1;
      if (drain_end && !retry_ok) begin
        timeout_err <= 1'b1;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: vector table plus scoreboard of done-time results for two checker configurations
module tb_sysid_checker;
  localparam logic [31:0] EID = 32'h2E58_4ECF;
  localparam logic [31:0] ETS = 32'h4FBE_6064;
  typedef struct {
    logic io, to, te, cv;
    logic [31:0] iv, tv;
    int lat, t0;
  } exp_t;
  typedef struct {
    logic [31:0] id, ts;
    int stall;
    logic io, to;
    int lat;
  } vec_t;
  logic clk, reset_n;
  logic [1:0] start, rd, addr, wr, rdv, busy, done, iok, tok, terr;
  logic [1:0] resp_id, resp_ts, inj;
  logic [31:0] rdata[2], idv[2], tsv[2], sid[2], sts[2];
  int stall_n[2];
  int ndone[2];
  int cyc, total, bad;
  exp_t qa[$], qb[$];
  vec_t v[5];
  logic hold_p, addr_p;
  sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(255), .MAX_RETRY(3), .DRAIN_CYCLES(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
    .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]), .busy(busy[0]),
    .done(done[0]), .id_ok(iok[0]), .ts_ok(tok[0]), .timeout_err(terr[0]), .id_value(idv[0]), .ts_value(tsv[0])
  );
  sysid_checker #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(8), .MAX_RETRY(2), .DRAIN_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
    .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]), .busy(busy[1]),
    .done(done[1]), .id_ok(iok[1]), .ts_ok(tok[1]), .timeout_err(terr[1]), .id_value(idv[1]), .ts_value(tsv[1])
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : sl
    int sc = 0;
    int nacc_id = 0;
    logic vq = 1'b0;
    logic [31:0] dq = '0;
    assign wr[g]    = rd[g] && (sc < stall_n[g]);
    assign rdv[g]   = vq || inj[g];
    assign rdata[g] = inj[g] ? 32'hBAD0_0BAD : dq;
    always @(posedge clk) begin
      vq <= 1'b0;
      if (rd[g] && wr[g]) sc <= sc + 1;
      if (rd[g] && !wr[g]) begin
        sc <= 0;
        vq <= addr[g] ? resp_ts[g] : resp_id[g];
        dq <= addr[g] ? sts[g] : sid[g];
        if (!addr[g]) nacc_id <= nacc_id + 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask
  task automatic score(input int k);
    exp_t e;
    if ((k == 0 ? qa.size() : qb.size()) == 0) chk("spurious_done", 32'(done[k]), 0);
    else begin
      if (k == 0) e = qa.pop_front();
      else e = qb.pop_front();
      chk("latency", cyc - e.t0, e.lat);
      chk("id_ok", 32'(iok[k]), 32'(e.io));
      chk("ts_ok", 32'(tok[k]), 32'(e.to));
      chk("timeout_err", 32'(terr[k]), 32'(e.te));
      chk("busy_at_done", 32'(busy[k]), 0);
      if (e.cv) begin
        chk("id_value", idv[k], e.iv);
        chk("ts_value", tsv[k], e.tv);
      end
    end
    ndone[k]++;
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) if (done[k]) score(k);
    if (hold_p) begin
      chk("stall_read", 32'(rd[0]), 1);
      chk("stall_addr", 32'(addr[0]), 32'(addr_p));
    end
    hold_p = rd[0] && wr[0];
    addr_p = addr[0];
  end
  task automatic launch(input int k, input exp_t e, output int n0);
    @(negedge clk);
    n0 = ndone[k];
    e.t0 = cyc;
    if (k == 0) qa.push_back(e);
    else qb.push_back(e);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    chk("busy_after_start", 32'(busy[k]), 1);
  endtask
  task automatic wait_done(input int k, input int n0);
    for (int g = 0; g < 400 && ndone[k] == n0; g++) @(negedge clk);
    if (ndone[k] == n0) chk("done_wait", ndone[k], n0 + 1);
  endtask
  initial begin
    exp_t e;
    int n0;
    v[0] = '{EID, ETS, 0, 1'b1, 1'b1, 7};
    v[1] = '{32'hDEAD_BEEF, ETS, 0, 1'b0, 1'b1, 7};
    v[2] = '{EID, ETS, 10, 1'b1, 1'b1, 27};
    v[3] = '{EID, 32'h0, 0, 1'b1, 1'b0, 7};
    v[4] = '{32'h1234_5678, 32'h8765_4321, 3, 1'b0, 1'b0, 13};
    cyc = 0; total = 0; bad = 0; ndone = '{0, 0};
    hold_p = 1'b0; addr_p = 1'b0;
    reset_n = 1'b0; start = '0; inj = '0; resp_id = '1; resp_ts = '1;
    stall_n = '{0, 0}; sid = '{EID, EID}; sts = '{ETS, ETS};
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(rd[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_id_ok", 32'(iok[0]), 0);
    chk("rst_terr", 32'(terr[0]), 0);
    chk("rst_id_value", idv[0], 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sid[0] = v[i].id; sts[0] = v[i].ts; stall_n[0] = v[i].stall;
      e = '{io: v[i].io, to: v[i].to, te: 1'b0, cv: 1'b1, iv: v[i].id, tv: v[i].ts, lat: v[i].lat, t0: 0};
      launch(0, e, n0);
      wait_done(0, n0);
    end
    resp_id[1] = 1'b0; resp_ts[1] = 1'b0;
    e = '{io: 1'b0, to: 1'b0, te: 1'b1, cv: 1'b0, iv: 32'h0, tv: 32'h0, lat: 74, t0: 0};
    launch(1, e, n0);
    wait_done(1, n0);
    chk("retry_id_reads", sl[1].nacc_id, 3);
    e = '{io: 1'b1, to: 1'b1, te: 1'b0, cv: 1'b1, iv: EID, tv: ETS, lat: 31, t0: 0};
    launch(1, e, n0);
    repeat (11) @(negedge clk);
    inj[1] = 1'b1;
    @(negedge clk);
    inj[1] = 1'b0; resp_id[1] = 1'b1; resp_ts[1] = 1'b1;
    wait_done(1, n0);
    chk("late_id_reads", sl[1].nacc_id, 5);
    sid[0] = EID; sts[0] = ETS; stall_n[0] = 0; resp_ts[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_read", 32'(rd[0]), 0);
    chk("mid_rst_addr", 32'(addr[0]), 0);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_done", 32'(done[0]), 0);
    chk("mid_rst_id_ok", 32'(iok[0]), 0);
    chk("mid_rst_ts_ok", 32'(tok[0]), 0);
    chk("mid_rst_terr", 32'(terr[0]), 0);
    chk("mid_rst_id_value", idv[0], 0);
    chk("mid_rst_ts_value", tsv[0], 0);
    chk("mid_rst_b_id_value", idv[1], 0);
    repeat (40) @(negedge clk);
    chk("idle_after_rst", 32'(busy[0]), 0);
    resp_ts[0] = 1'b1;
    e = '{io: 1'b1, to: 1'b1, te: 1'b0, cv: 1'b1, iv: EID, tv: ETS, lat: 7, t0: 0};
    launch(0, e, n0);
    wait_done(0, n0);
    repeat (3) @(negedge clk);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sequences a boot-time integrity check of the system-ID slave.
- The slave is a 1-bit-address, 32-bit read-only port: address 0 returns the system ID word, address 1 returns the build timestamp word.
- On a start pulse the block reads both words, compares them against parameterised expected values and reports pass/fail/timeout status to the boot controller.
- It sits between the boot/reset sequencer and the system-ID slave's control port, and retries on bus timeouts.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected word at address 0
- EXPECTED_TS, 32'h0000_0000, expected word at address 1
- TIMEOUT_CYCLES, 255, max cycles per read phase (stall plus response wait), 1..65535
- MAX_RETRY, 3, full-sequence retries after a timeout, 0..15
- DRAIN_CYCLES, 16, quiet cycles after a timeout during which readdatavalid is discarded

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to run the check; ignored while busy=1
- avm_address  out  1  slave word select (0=ID, 1=timestamp)
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- id_ok  out  1  sticky: ID matched
- ts_ok  out  1  sticky: timestamp matched
- timeout_err  out  1  sticky: retries exhausted
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset (reset_n=0 at a clk edge) has priority over everything, including mid-sequence.
  - State goes to IDLE.
  - All outputs go to 0: avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value.
  - Retry and timeout counters clear.
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DRAIN, FINISH.
- IDLE
  - start=1 clears id_ok, ts_ok, timeout_err and the retry count, then enters RD_ID next cycle.
  - busy=1 from the cycle after start.
- RD_ID: avm_read=1, avm_address=0, held stable while avm_waitrequest=1. The read is accepted on a cycle with avm_read=1 and avm_waitrequest=0; go to WAIT_ID.
- WAIT_ID: avm_read=0. On avm_readdatavalid=1, capture avm_readdata into id_value and go to RD_TS.
- RD_TS / WAIT_TS: same as the ID states, with avm_address=1; capture into ts_value and go to CHECK.
- CHECK: one cycle.
  - id_ok <= (id_value==EXPECTED_ID); ts_ok <= (ts_value==EXPECTED_TS).
  - Go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Timeout counter
  - Reloads to 0 on entry to RD_ID and RD_TS.
  - Increments every cycle in RD_x and WAIT_x; it is not reset between RD_x and WAIT_x of the same word.
  - Count reaching TIMEOUT_CYCLES forces a drop of avm_read and entry to DRAIN.
- DRAIN
  - Waits DRAIN_CYCLES, ignoring avm_readdatavalid.
  - Then: if retry count < MAX_RETRY, increment it and go to RD_ID (full restart, both words re-read).
  - Otherwise set timeout_err=1, id_ok=ts_ok=0, and go to FINISH.
- avm_readdatavalid outside WAIT_x is ignored; no capture.
- Exactly one outstanding read at a time; no pipelining.
- Simultaneous events:
  - readdatavalid on the same cycle the timeout count is reached: data wins and is captured; no timeout.
  - readdatavalid in the same cycle the read is accepted is not legal for this slave class; it is ignored.
- Captured values persist until the next start or reset; status flags are sticky until then.
- Counter widths: timeout 16 bits, retry 4 bits, drain 8 bits; no wrap is possible within legal parameter ranges.

Decomposition:
- Shared package sysid_pkg:
  - state enum
  - address constants SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1
  - counter width constants
- One natural sub-module: sysid_rd_phase.
  - Issues one Avalon read with waitrequest handling and timeout.
  - Returns data/valid/timeout.
  - Instantiated once and reused for both words under the top FSM.

Test Plan:
- EXPECTED_ID=32'h2E58_4ECF, EXPECTED_TS=32'h4FBE_6064; slave returns those values with zero waitrequest and 1-cycle readdatavalid latency; pulse start → done pulses 7 cycles after start, id_ok=1, ts_ok=1, timeout_err=0, id_value and ts_value match.
- Slave returns ID 32'hDEAD_BEEF → done with id_ok=0, ts_ok=1, id_value=32'hDEAD_BEEF.
- waitrequest held high 10 cycles on each read, TIMEOUT_CYCLES=255 → pass; avm_address and avm_read stable throughout the stall.
- Slave never asserts readdatavalid, TIMEOUT_CYCLES=8, MAX_RETRY=2 → 3 full attempts, each followed by 16 drain cycles, then done with timeout_err=1, id_ok=0, ts_ok=0.
- Late readdatavalid injected during DRAIN, followed by a good response on retry → late data ignored, final id_value equals the retry data, pass.
- reset_n low mid-WAIT_TS, plus a start pulse while busy → all outputs 0 the cycle after reset; the start pulse while busy produces no extra sequence or done pulse.
